// File: rtl/fpu_issue_ctrl.sv
// Issue/capture stage in front of FPU_top: command FIFO, run/idle sequencing,
// edge-detected completion, watchdog abort, response channel and sticky flags.
module fpu_issue_ctrl #(
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [1:0]  cmd_rm,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        fpu_reset,
  output logic [3:0]  fpu_opCode,
  output logic [1:0]  fpu_roundingMode,
  output logic [31:0] fpu_A,
  output logic [31:0] fpu_B,
  input  logic        fpu_resultReady,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_flags,
  output logic        rsp_timeout,
  output logic [4:0]  sticky_flags,
  input  logic        sticky_clr,
  output logic        busy
);

  localparam int ADDR = $clog2(DEPTH);
  localparam int SW   = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam int WW   = $clog2(TIMEOUT);

  typedef struct packed {
    logic [3:0]  op;
    logic [1:0]  rm;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    RUN,
    RECOVER
  } state_t;

  cmd_t            mem [DEPTH];
  cmd_t            cmdIn;
  cmd_t            head;
  cmd_t            shown;
  cmd_t            holdQ;
  logic [ADDR-1:0] wrPtr;
  logic [ADDR-1:0] rdPtr;
  logic [ADDR:0]   count;
  logic [ADDR:0]   countNext;
  logic            cmdReadyQ;
  logic            push;
  logic            pop;

  state_t          state;
  state_t          stateNext;
  logic [SW-1:0]   setupCnt;
  logic [SW-1:0]   setupCntNext;
  logic [WW-1:0]   wdCnt;
  logic [WW-1:0]   wdCntNext;
  logic            rrQ;
  logic            done;
  logic            capture;
  logic            abort;

  logic            rspValidQ;
  logic [31:0]     rspResultQ;
  logic [4:0]      rspFlagsQ;
  logic            rspTimeoutQ;
  logic [4:0]      stickyQ;
  logic            rspFire;

  assign cmdIn = '{op: cmd_op, rm: cmd_rm, a: cmd_a, b: cmd_b};
  assign push  = cmd_valid & cmdReadyQ;
  assign countNext = count
                   + {{ADDR{1'b0}}, push}
                   - {{ADDR{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= cmdIn;
    end
  end

  // cmd_ready reflects occupancy after this edge, so a full FIFO never
  // accepts even when a pop lands in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      cmdReadyQ <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + {{(ADDR-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rdPtr <= rdPtr + {{(ADDR-1){1'b0}}, 1'b1};
      end
      count     <= countNext;
      cmdReadyQ <= (countNext != (ADDR+1)'(DEPTH));
    end
  end

  assign head  = mem[rdPtr];
  assign shown = (count != '0) ? head : holdQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      holdQ <= '0;
    end else begin
      holdQ <= shown;
    end
  end

  assign fpu_opCode       = shown.op;
  assign fpu_roundingMode = shown.rm;
  assign fpu_A            = shown.a;
  assign fpu_B            = shown.b;

  assign done = fpu_resultReady & ~rrQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      setupCnt <= '0;
      wdCnt    <= '0;
      rrQ      <= 1'b0;
    end else begin
      state    <= stateNext;
      setupCnt <= setupCntNext;
      wdCnt    <= wdCntNext;
      rrQ      <= fpu_resultReady;
    end
  end

  always_comb begin
    stateNext    = state;
    setupCntNext = setupCnt;
    wdCntNext    = wdCnt;
    pop          = 1'b0;
    capture      = 1'b0;
    abort        = 1'b0;
    unique case (state)
      IDLE: begin
        if ((count != '0) && !rspValidQ) begin
          stateNext    = SETUP;
          setupCntNext = '0;
        end
      end
      SETUP: begin
        if (setupCnt == SW'(SETUP_CYC - 1)) begin
          stateNext = RUN;
          wdCntNext = '0;
        end else begin
          setupCntNext = setupCnt + {{(SW-1){1'b0}}, 1'b1};
        end
      end
      RUN: begin
        wdCntNext = wdCnt + {{(WW-1){1'b0}}, 1'b1};
        // A real completion wins over a watchdog expiry in the same cycle.
        if (done) begin
          capture   = 1'b1;
          pop       = 1'b1;
          stateNext = RECOVER;
        end else if (wdCnt == WW'(TIMEOUT - 1)) begin
          abort     = 1'b1;
          pop       = 1'b1;
          stateNext = RECOVER;
        end
      end
      RECOVER: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign fpu_reset = (state != RUN);
  assign busy      = (state != IDLE) || (count != '0);

  assign rspFire = rspValidQ & rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rspValidQ   <= 1'b0;
      rspResultQ  <= '0;
      rspFlagsQ   <= '0;
      rspTimeoutQ <= 1'b0;
    end else if (capture) begin
      rspValidQ   <= 1'b1;
      rspResultQ  <= fpu_result;
      rspFlagsQ   <= fpu_flags;
      rspTimeoutQ <= 1'b0;
    end else if (abort) begin
      rspValidQ   <= 1'b1;
      rspResultQ  <= 32'h7FC00000;
      rspFlagsQ   <= 5'b10000;
      rspTimeoutQ <= 1'b1;
    end else if (rspFire) begin
      rspValidQ <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stickyQ <= '0;
    end else if (rspFire) begin
      stickyQ <= sticky_clr ? rspFlagsQ : (stickyQ | rspFlagsQ);
    end else if (sticky_clr) begin
      stickyQ <= '0;
    end
  end

  assign cmd_ready    = cmdReadyQ;
  assign rsp_valid    = rspValidQ;
  assign rsp_result   = rspResultQ;
  assign rsp_flags    = rspFlagsQ;
  assign rsp_timeout  = rspTimeoutQ;
  assign sticky_flags = stickyQ;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl with a behavioural FPU_top stand-in
// and a queue-based reference model of response order, timeouts and sticky flags.
module tb_fpu_issue_ctrl;

  localparam int DEPTH     = 4;
  localparam int SETUP_CYC = 2;
  localparam int TIMEOUT   = 64;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_DIV = 4'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [1:0]  cmd_rm;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        fpu_reset;
  logic [3:0]  fpu_opCode;
  logic [1:0]  fpu_roundingMode;
  logic [31:0] fpu_A;
  logic [31:0] fpu_B;
  logic        fpu_resultReady;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_flags;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_flags;
  logic        rsp_timeout;
  logic [4:0]  sticky_flags;
  logic        sticky_clr;
  logic        busy;

  fpu_issue_ctrl #(
    .DEPTH(DEPTH),
    .SETUP_CYC(SETUP_CYC),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_rm(cmd_rm),
    .cmd_a(cmd_a),
    .cmd_b(cmd_b),
    .fpu_reset(fpu_reset),
    .fpu_opCode(fpu_opCode),
    .fpu_roundingMode(fpu_roundingMode),
    .fpu_A(fpu_A),
    .fpu_B(fpu_B),
    .fpu_resultReady(fpu_resultReady),
    .fpu_result(fpu_result),
    .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_result(rsp_result),
    .rsp_flags(rsp_flags),
    .rsp_timeout(rsp_timeout),
    .sticky_flags(sticky_flags),
    .sticky_clr(sticky_clr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    logic        to;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  bit   hang = 0;
  bit   stuck = 0;
  bit   randLat = 0;
  bit   randRsp = 0;
  int   lat = 3;

  // Behaviour of the FPU seen through the stage: deterministic per operands.
  function automatic logic [36:0] fpuFn(input logic [3:0] op,
                                        input logic [1:0] rm,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    if (op == OP_ADD && a == 32'h3F800000 && b == 32'h40000000)
      return {5'b00000, 32'h40400000};
    if (op == OP_DIV && b == 32'h0)
      return {5'b01000, 32'h7F800000};
    return {a[4:0] ^ b[9:5] ^ {1'b0, op},
            a ^ {b[15:0], b[31:16]} ^ {26'd0, rm, op}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  // FPU_top stand-in: raises resultReady `lat` cycles into RUN; in stuck
  // mode the level persists and is dropped 4 cycles into the next RUN.
  initial begin
    int  runCnt;
    bit  stale;
    logic [36:0] r;
    runCnt = 0;
    stale = 0;
    fpu_resultReady = 1'b0;
    fpu_result = '0;
    fpu_flags = '0;
    forever begin
      @(posedge clk);
      #1;
      if (fpu_reset) begin
        runCnt = 0;
        if (!stuck) fpu_resultReady = 1'b0;
        stale = fpu_resultReady;
        if (randLat) lat = $urandom_range(1, 8);
      end else begin
        runCnt++;
        if (stale) begin
          if (runCnt == 4) begin
            fpu_resultReady = 1'b0;
            stale = 0;
            runCnt = 0;
          end
        end else if (!hang && !fpu_resultReady && runCnt == lat) begin
          r = fpuFn(fpu_opCode, fpu_roundingMode, fpu_A, fpu_B);
          fpu_result = r[31:0];
          fpu_flags = r[36:32];
          fpu_resultReady = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each response handshake and tracks
  // the sticky flags as the OR of delivered flags since the last clear.
  initial begin
    logic [4:0] sk;
    exp_t e;
    sk = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!reset) begin
        sk = '0;
        continue;
      end
      chk("sticky", 64'(sticky_flags), 64'(sk));
      if (rsp_valid && !fpu_reset) begin
        checks++;
        errors++;
        $display("FAIL rspWhileRun got fpu_reset 0 want 1");
      end
      if (rsp_valid && rsp_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpectedRsp got %h want none", rsp_result);
        end else begin
          e = expQ.pop_front();
          chk("rsp", {26'd0, rsp_timeout, rsp_flags, rsp_result},
              {26'd0, e.to, e.fl, e.res});
          sk = sticky_clr ? e.fl : (sk | e.fl);
        end
      end else if (sticky_clr) begin
        sk = '0;
      end
    end
  end

  task automatic rnd();
    if (randRsp) begin
      rsp_ready = ($urandom % 4) != 0;
      sticky_clr = ($urandom % 8) == 0;
    end
  endtask

  task automatic sendCmd(input logic [3:0] op, input logic [1:0] rm,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit expTo);
    int n;
    logic [36:0] r;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_rm = rm;
    cmd_a = a;
    cmd_b = b;
    rnd();
    n = 0;
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      rnd();
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmdAccept got ready 0 want 1");
    end else begin
      r = fpuFn(op, rm, a, b);
      e.res = expTo ? 32'h7FC00000 : r[31:0];
      e.fl = expTo ? 5'b10000 : r[36:32];
      e.to = expTo;
      expQ.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    rsp_ready = 1'b1;
    sticky_clr = 1'b0;
    n = 0;
    while ((expQ.size() != 0 || busy || rsp_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(expQ.size() == 0 && !busy && !rsp_valid), 64'(1));
  endtask

  initial begin
    int n;
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_rm = '0;
    cmd_a = '0;
    cmd_b = '0;
    rsp_ready = 1'b0;
    sticky_clr = 1'b0;

    #2;
    chk("rstCmdReady", 64'(cmd_ready), 64'(0));
    chk("rstFpuReset", 64'(fpu_reset), 64'(1));
    chk("rstRsp", {26'd0, rsp_valid, rsp_timeout, rsp_flags, rsp_result},
        64'(0));
    chk("rstBusySticky", 64'({busy, sticky_flags}), 64'(0));
    chk("rstOperands", {fpu_opCode, fpu_roundingMode, fpu_A[31:0]}, 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("cmdReadyAfterRst", 64'(cmd_ready), 64'(1));

    // Single ADD: 1.0 + 2.0, launch timing.
    lat = 4;
    rsp_ready = 1'b1;
    sendCmd(OP_ADD, 2'b01, 32'h3F800000, 32'h40000000, 0);
    chk("busyAfterAccept", 64'(busy), 64'(1));
    n = 0;
    while (fpu_reset && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("launchLatency", 64'(n), 64'(SETUP_CYC + 1));
    chk("headOperands", {fpu_A, fpu_B}, {32'h3F800000, 32'h40000000});
    waitIdle();

    // Fill with responses blocked.
    lat = 3;
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      sendCmd(4'($urandom), 2'($urandom), $urandom, $urandom | 32'h1, 0);
    chk("fullNotReady", 64'(cmd_ready), 64'(0));
    cmd_valid = 1'b1;
    cmd_op = 4'd7;
    cmd_rm = 2'd2;
    cmd_a = 32'h12345678;
    cmd_b = 32'h9ABCDEF0;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("readyWithCapture", 64'({cmd_ready, rsp_valid}), 64'(3));
    begin
      exp_t e;
      logic [36:0] r;
      r = fpuFn(4'd7, 2'd2, 32'h12345678, 32'h9ABCDEF0);
      e.res = r[31:0];
      e.fl = r[36:32];
      e.to = 1'b0;
      expQ.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("refull", 64'(cmd_ready), 64'(0));
    waitIdle();

    // Divide by zero, sticky clear coinciding with the handshake.
    rsp_ready = 1'b0;
    sendCmd(OP_DIV, 2'b00, 32'h3F800000, 32'h00000000, 0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("divFlags", 64'(rsp_flags), 64'(5'b01000));
    sticky_clr = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    chk("stickyAfterClr", 64'(sticky_flags), 64'(5'b01000));
    waitIdle();

    // Watchdog abort.
    hang = 1;
    rsp_ready = 1'b0;
    sendCmd(4'd2, 2'd0, 32'h40000000, 32'h40400000, 1);
    n = 0;
    while (fpu_reset && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!fpu_reset && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("timeoutCycles", 64'(n), 64'(TIMEOUT));
    chk("timeoutRsp", 64'({rsp_valid, rsp_timeout}), 64'(3));
    hang = 0;
    waitIdle();

    // Reset in the middle of RUN with three entries queued.
    lat = 20;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      sendCmd(4'($urandom), 2'($urandom), $urandom, $urandom | 32'h1, 0);
    n = 0;
    while (fpu_reset && n < 20) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b0;
    #1;
    chk("rstMidRun", 64'({fpu_reset, rsp_valid, cmd_ready}), 64'(3'b100));
    expQ.delete();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstReleaseBusy", 64'(busy), 64'(0));
    @(negedge clk);
    chk("rstReleaseReady", 64'({cmd_ready, busy}), 64'(2'b10));
    waitIdle();

    // resultReady left high across RECOVER into the next RUN.
    lat = 2;
    stuck = 1;
    sendCmd(4'd1, 2'd0, 32'hAAAA0000, 32'h00005555, 0);
    sendCmd(4'd5, 2'd3, 32'h0F0F0F0F, 32'hF0F0F0F1, 0);
    waitIdle();
    stuck = 0;
    repeat (3) @(negedge clk);

    // Randomized traffic.
    randLat = 1;
    randRsp = 1;
    for (int i = 0; i < 40; i++) begin
      sendCmd(4'($urandom), 2'($urandom), $urandom, $urandom | 32'h1, 0);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        rnd();
      end
    end
    randRsp = 0;
    waitIdle();
    randLat = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL globalTimeout got running want finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Command-issue and result-capture stage that sits directly upstream of FPU_top. It buffers FPU commands in a small FIFO and sequences FPU_top's run/idle control input, holding it high while idle and releasing it to start an operation. It detects completion on the rising edge of resultReady, then returns the result and exception flags on a valid/ready response channel while accumulating sticky IEEE flags. A watchdog aborts operations that never complete.

## Interface
- DEPTH, 4 — command FIFO entries; power of two, ≥2.
- SETUP_CYC, 2 — cycles operands are held stable with FPU_top idle before release; ≥1.
- TIMEOUT, 64 — maximum cycles in RUN before abort; ≥8.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; transfer when cmd_valid & cmd_ready.
- cmd_op  in  4  FPU opcode (`FPU_INSTR_*).
- cmd_rm  in  2  rounding mode (`ROUNDING_MODE_*).
- cmd_a, cmd_b  in  32  operands.
- fpu_reset  out  1  drives FPU_top reset; 1 = idle/clear, 0 = run.
- fpu_opCode  out  4, fpu_roundingMode  out  2, fpu_A / fpu_B  out  32  — FIFO head fields.
- fpu_resultReady  in  1; fpu_result  in  32; fpu_flags  in  5 {invalid, divByZero, overflow, underflow, inexact}.
- rsp_valid  out  1; rsp_ready  in  1; rsp_result  out  32; rsp_flags  out  5; rsp_timeout  out  1.
- sticky_flags  out  5  OR of all delivered rsp_flags since reset/clear.
- sticky_clr  in  1  synchronous clear of sticky_flags.
- busy  out  1  state ≠ IDLE or FIFO non-empty.

## Operation
- FIFO: DEPTH entries of {op, rm, a, b} (70 bits); write pointer, read pointer, count of ADDR+1 bits. Pointers wrap modulo DEPTH.
- cmd_ready is registered as (count ≠ DEPTH), evaluated after this edge's push and pop. It is 0 while reset is asserted. A push into a full FIFO is impossible, even when a pop occurs in the same cycle.
- FSM states: IDLE, SETUP, RUN, RECOVER.
- IDLE: fpu_reset = 1. Go to SETUP when count ≠ 0 and rsp_valid = 0.
- SETUP: fpu_reset = 1; head fields drive the fpu_* outputs. After SETUP_CYC cycles, go to RUN and clear the watchdog counter.
- RUN: fpu_reset = 0; watchdog increments each cycle. Completion is (fpu_resultReady & ~rr_q), where rr_q is fpu_resultReady registered one cycle. On completion:
  - capture fpu_result and fpu_flags into the response register;
  - set rsp_valid, rsp_timeout = 0;
  - pop the FIFO;
  - go to RECOVER.
- Timeout: if the watchdog reaches TIMEOUT-1 with no completion, capture result 32'h7FC00000 with flags 5'b10000, set rsp_timeout = 1, pop, and go to RECOVER. Completion takes precedence if both occur in the same cycle.
- RECOVER: fpu_reset = 1 for exactly one cycle, then IDLE.
- Response channel: rsp_valid holds until rsp_ready. Capture can only happen while rsp_valid = 0, so the single register never overflows.
- Sticky flags:
  - sticky_flags |= rsp_flags on each response handshake (rsp_valid & rsp_ready).
  - sticky_clr alone zeroes them.
  - sticky_clr in the same cycle as a handshake sets sticky_flags = rsp_flags of that response.
- The fpu_* operand outputs show the FIFO head whenever count ≠ 0 and hold their last value when empty.

## Timing
- Reset values: cmd_ready 0, fpu_reset 1, fpu_opCode/fpu_roundingMode/fpu_A/fpu_B 0, rsp_valid 0, rsp_result 0, rsp_flags 0, rsp_timeout 0, sticky_flags 0, busy 0, state IDLE, count 0.
- Reset assertion mid-operation immediately forces fpu_reset = 1 and discards FIFO contents and any pending response.
- Accept at edge k into an empty FIFO while idle: busy = 1 after edge k; SETUP after edge k+1; RUN (fpu_reset = 0) after edge k+1+SETUP_CYC.
- Completion detected in cycle c: rsp_valid = 1 after edge c, fpu_reset = 1 after edge c, IDLE after edge c+1.
- The next launch reaches SETUP no earlier than edge c+2 and only after the response handshake.
- Back-to-back issue overhead: 2+SETUP_CYC cycles plus FPU latency, with rsp_ready tied high.
- A resultReady level that stays high from a prior operation does not retrigger; only a 0→1 edge completes.

## Test plan
- Single op: ADD 3F800000 + 40000000, truncate. Required: fpu_reset falls 3 cycles after accept (SETUP_CYC = 2); rsp_result 40400000, flags 0, rsp_timeout 0.
- Fill: push 5 commands with rsp_ready = 0 and DEPTH = 4. Required: cmd_ready = 0 after the 4th push, 5th held off. One response is captured; cmd_ready returns to 1 one cycle after that pop. All results emerge in FIFO order.
- Flags: DIV 3F800000 / 00000000, then sticky_clr in the cycle of that handshake. Required: rsp_flags 01000, sticky_flags = 01000 afterwards.
- Timeout: FPU model never raises resultReady. Required: after TIMEOUT cycles in RUN, rsp_result 7FC00000, rsp_flags 10000, rsp_timeout 1, fpu_reset = 1 next cycle.
- Reset mid-RUN with 3 entries queued: reset low for 1 cycle. Required: fpu_reset = 1 and rsp_valid = 0 immediately; busy = 0 and count = 0 after release. cmd_ready = 1 on the first edge after deassertion.
- Stuck-high resultReady: hold resultReady high across RECOVER into the next RUN. Required: no completion until it drops and rises again.
